// File: rtl/lzss_pkg.sv
// Shared constants, codeword field layout and FSM encoding for the LZSS decoder.
package lzss_pkg;

    localparam int CW_W    = 11;
    localparam int OFF_W   = 7;
    localparam int LEN_W   = 3;
    localparam int MAX_LEN = 5;
    localparam int WIN     = 1 << OFF_W;

    localparam int CW_FLAG    = 10;
    localparam int CW_OFF_LSB = 3;
    localparam int CW_LEN_LSB = 0;
    localparam int CW_LIT_LSB = 0;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_EMIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lzss_history.sv
// Sliding history window: synchronous write, combinational read, cleared on reset.
module lzss_history
    import lzss_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [OFF_W-1:0] i_waddr,
    input  logic [7:0]       i_wdata,
    input  logic [OFF_W-1:0] i_raddr,
    output logic [7:0]       o_rdata
);

    logic [7:0] r_mem [WIN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lzss_decoder.sv
// LZSS decoder: expands literal/match codewords into bytes and packs them into
// little-endian 32-bit words, with a final partial-word flush at end of stream.
module lzss_decoder
    import lzss_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [CW_W-1:0] codeword,
    input  logic            cw_valid,
    output logic            cw_ready,
    input  logic            finish,
    input  logic [11:0]     enc_num,
    output logic [31:0]     out_data,
    output logic            out_valid,
    output logic [2:0]      out_bytes,
    output logic            done,
    output logic            err,
    output logic [1:0]      o_dbg_state
);

    // Handshake: a codeword transfers on a rising edge where cw_valid && cw_ready;
    // the source holds codeword stable while cw_valid is high and not yet accepted.

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic [LEN_W-1:0]   r_rem;
    logic               r_is_lit;
    logic [7:0]         r_lit;
    logic [OFF_W-1:0]   r_dist_m1;
    logic [OFF_W-1:0]   r_wptr;
    logic [OFF_W:0]     r_written;
    logic [1:0]         r_pack_cnt;
    logic [23:0]        r_pack_data;
    logic [11:0]        r_cw_cnt;
    logic               r_fin;
    logic [11:0]        r_enc_num;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic [2:0]         r_out_bytes;
    logic               r_err;

    logic               w_cw_match;
    logic [LEN_W-1:0]   w_cw_len;
    logic [OFF_W-1:0]   w_cw_dist_m1;
    logic               w_len_ok;
    logic               w_dist_bad;
    logic [OFF_W-1:0]   w_rd_addr;
    logic [7:0]         w_hist_rdata;
    logic [7:0]         w_byte;

    assign w_cw_match   = codeword[CW_FLAG];
    assign w_cw_len     = codeword[CW_LEN_LSB +: LEN_W];
    assign w_cw_dist_m1 = codeword[CW_OFF_LSB +: OFF_W];
    assign w_len_ok     = (w_cw_len != '0) && (w_cw_len <= LEN_W'(MAX_LEN));
    assign w_dist_bad   = ({1'b0, w_cw_dist_m1} + (OFF_W + 1)'(1)) > r_written;

    // distance = dist_m1 + 1, so the read address is wptr - dist_m1 - 1 (mod window)
    assign w_rd_addr = r_wptr - r_dist_m1 - OFF_W'(1);
    assign w_byte    = r_is_lit ? r_lit : w_hist_rdata;

    lzss_history u_history (
        .clk     (clk),
        .reset   (reset),
        .i_we    (r_state == S_EMIT),
        .i_waddr (r_wptr),
        .i_wdata (w_byte),
        .i_raddr (w_rd_addr),
        .o_rdata (w_hist_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        cw_ready    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_WAIT: begin
                cw_ready = 1'b1;
                if (cw_valid) begin
                    w_accept = 1'b1;
                    // a match with an illegal length is counted but emits nothing
                    if (!w_cw_match || w_len_ok) w_state_nxt = S_EMIT;
                end else if (r_fin && (r_cw_cnt == r_enc_num)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_EMIT: begin
                if (r_rem == LEN_W'(1)) w_state_nxt = S_WAIT;
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  done = 1'b1;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem       <= '0;
            r_is_lit    <= 1'b0;
            r_lit       <= '0;
            r_dist_m1   <= '0;
            r_wptr      <= '0;
            r_written   <= '0;
            r_pack_cnt  <= '0;
            r_pack_data <= '0;
            r_cw_cnt    <= '0;
            r_fin       <= 1'b0;
            r_enc_num   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_bytes <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            if (finish && !r_fin && (r_state != S_DONE)) begin
                r_fin     <= 1'b1;
                r_enc_num <= enc_num;
            end

            if (w_accept) begin
                r_cw_cnt  <= r_cw_cnt + 12'd1;
                r_is_lit  <= !w_cw_match;
                r_lit     <= codeword[CW_LIT_LSB +: 8];
                r_dist_m1 <= w_cw_dist_m1;
                r_rem     <= w_cw_match ? w_cw_len : LEN_W'(1);
                if (w_cw_match && (!w_len_ok || w_dist_bad)) r_err <= 1'b1;
            end

            if ((r_state == S_WAIT) && r_fin && (r_cw_cnt > r_enc_num)) r_err <= 1'b1;

            if (r_state == S_EMIT) begin
                r_wptr <= r_wptr + OFF_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
                if (!r_written[OFF_W]) r_written <= r_written + (OFF_W + 1)'(1);
                r_pack_cnt <= r_pack_cnt + 2'd1;
                case (r_pack_cnt)
                    2'd0: r_pack_data[7:0]   <= w_byte;
                    2'd1: r_pack_data[15:8]  <= w_byte;
                    2'd2: r_pack_data[23:16] <= w_byte;
                    default: begin
                        r_out_data  <= {w_byte, r_pack_data};
                        r_out_valid <= 1'b1;
                        r_out_bytes <= 3'd4;
                        r_pack_data <= '0;
                    end
                endcase
            end

            // unused upper bytes are already zero because pack_data clears per word
            if ((r_state == S_FLUSH) && (r_pack_cnt != 2'd0)) begin
                r_out_data  <= {8'h00, r_pack_data};
                r_out_valid <= 1'b1;
                r_out_bytes <= {1'b0, r_pack_cnt};
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_bytes   = r_out_bytes;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lzss_decoder.sv
// Directed bench for lzss_decoder: expected output words queued per test,
// compared by a monitor whenever out_valid pulses.
module tb_lzss_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] codeword = '0;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic        finish = 1'b0;
    logic [11:0] enc_num = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  out_bytes;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    logic [34:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    lzss_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .codeword    (codeword),
        .cw_valid    (cw_valid),
        .cw_ready    (cw_ready),
        .finish      (finish),
        .enc_num     (enc_num),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_bytes   (out_bytes),
        .done        (done),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_word: unexpected word %h bytes %0d, none expected", out_data, out_bytes);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_bytes, out_data}, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cw_valid = 1'b0;
        finish = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [10:0] cw, output int n_wait);
        n_wait = 0;
        @(negedge clk);
        codeword = cw;
        cw_valid = 1'b1;
        while (!cw_ready && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        if (!cw_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: cw_ready 0 after %0d cycles, required 1", n_wait);
        end
        @(posedge clk);
    endtask

    task automatic send_cw(input logic [10:0] cw);
        int w;
        send(cw, w);
    endtask

    task automatic end_stream(input logic [11:0] n);
        @(negedge clk);
        cw_valid = 1'b0;
        finish = 1'b1;
        enc_num = n;
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, 35'(done), 35'(1));
        @(negedge clk);
        check({name, "_queue_left"}, 35'(exp_q.size()), 35'(0));
    endtask

    initial begin
        int w;
        fork
            monitor();
        join_none

        // reset values
        do_reset();
        check("rst_ready", 35'(cw_ready), 35'(1));
        check("rst_valid", 35'(out_valid), 35'(0));
        check("rst_data",  35'(out_data), 35'(0));
        check("rst_flags", 35'({done, err}), 35'(0));
        check("rst_state", 35'(dbg_state), 35'(0));

        // four literals -> one full word, nothing to flush
        exp_q.push_back({3'd4, 32'h44434241});
        send_cw(11'h041); send_cw(11'h042); send_cw(11'h043); send_cw(11'h044);
        end_stream(12'd4);
        wait_done("t1");
        check("t1_err", 35'(err), 35'(0));

        // literal plus overlapping distance-1 match -> 6 copies of 0x61
        do_reset();
        exp_q.push_back({3'd4, 32'h61616161});
        exp_q.push_back({3'd2, 32'h00006161});
        send_cw(11'h061); send_cw(11'h405);
        end_stream(12'd2);
        wait_done("t2");
        check("t2_err", 35'(err), 35'(0));

        // valid held high: match of length 4 stalls the next codeword for 4 cycles
        do_reset();
        exp_q.push_back({3'd4, 32'hAAAAAAAA});
        exp_q.push_back({3'd2, 32'h0000BBAA});
        send(11'h0AA, w);
        send(11'h404, w);
        check("t3_wait_after_lit", 35'(w), 35'(1));
        send(11'h0BB, w);
        check("t3_wait_after_match4", 35'(w), 35'(4));
        end_stream(12'd3);
        wait_done("t3");

        // distance beyond written data: err, zeros copied, decoding continues
        do_reset();
        exp_q.push_back({3'd4, 32'hC2C10000});
        send_cw(11'h412);
        send_cw(11'h0C1); send_cw(11'h0C2);
        end_stream(12'd3);
        wait_done("t4");
        check("t4_err", 35'(err), 35'(1));

        // 130 literals then distance-128 match: window wrap returns byte 2
        do_reset();
        for (int k = 0; k < 32; k++)
            exp_q.push_back({3'd4, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        exp_q.push_back({3'd3, 32'h00028180});
        for (int k = 0; k < 130; k++) send_cw(11'(k));
        send_cw(11'h7F9);
        end_stream(12'd131);
        wait_done("t5");
        check("t5_err", 35'(err), 35'(0));

        // reset in the middle of a length-5 match
        do_reset();
        send_cw(11'h011); send_cw(11'h405);
        @(negedge clk);
        @(negedge clk);
        check("t6_in_emit", 35'(dbg_state), 35'(1));
        reset = 1'b1;
        cw_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("t6_ready", 35'(cw_ready), 35'(1));
        check("t6_flags", 35'({out_valid, done, err}), 35'(0));
        exp_q.push_back({3'd4, 32'hD4D3D2D1});
        send_cw(11'h0D1); send_cw(11'h0D2); send_cw(11'h0D3); send_cw(11'h0D4);
        end_stream(12'd4);
        wait_done("t6");
        check("t6_err", 35'(err), 35'(0));

        // more codewords than enc_num: err, never done
        do_reset();
        send_cw(11'h001); send_cw(11'h002);
        end_stream(12'd1);
        repeat (20) @(negedge clk);
        check("t7_err", 35'(err), 35'(1));
        check("t7_not_done", 35'(done), 35'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
